// File: rtl/yazmac_obegi.sv
// Integer register file with busy-bit issue scoreboard for the c0 core.
// Serves two bypassed operand reads per issue through one registered output stage.
module yazmac_obegi #(
  parameter int VERI_BIT  = 32,
  parameter int ADRES_BIT = 5
) (
  input  logic                 clk_g,
  input  logic                 rst_g,
  input  logic                 yo_yaz_g,
  input  logic [ADRES_BIT-1:0] yo_yaz_hedef_g,
  input  logic [VERI_BIT-1:0]  yo_yaz_veri_g,
  input  logic                 coz_gecerli_g,
  output logic                 coz_hazir_c,
  input  logic [ADRES_BIT-1:0] coz_ky1_g,
  input  logic [ADRES_BIT-1:0] coz_ky2_g,
  input  logic                 coz_ky1_oku_g,
  input  logic                 coz_ky2_oku_g,
  input  logic [ADRES_BIT-1:0] coz_hy_g,
  input  logic                 coz_hy_yaz_g,
  output logic                 yurut_gecerli_c,
  output logic [VERI_BIT-1:0]  yurut_deger1_c,
  output logic [VERI_BIT-1:0]  yurut_deger2_c,
  input  logic                 yurut_hazir_g,
  input  logic                 boru_bosalt_g
);

  localparam int NREG = 1 << ADRES_BIT;

  // Entry 0 is never written and its busy bit is never set, so x0 stays zero and idle.
  logic [VERI_BIT-1:0] yazmac_q [NREG];
  logic [VERI_BIT-1:0] yazmac_d [NREG];
  logic [NREG-1:0]     mesgul_q, mesgul_d;
  logic                gecerli_q, gecerli_d;
  logic [VERI_BIT-1:0] deger1_q, deger1_d;
  logic [VERI_BIT-1:0] deger2_q, deger2_d;

  logic                yazma_etkin;
  logic [VERI_BIT-1:0] oku1_deger, oku2_deger;
  logic                raw1, raw2, waw, tehlike, aktarim;

  assign yazma_etkin = yo_yaz_g && (yo_yaz_hedef_g != '0);

  always_comb begin
    oku1_deger = '0;
    oku2_deger = '0;
    if (coz_ky1_g != '0)
      oku1_deger = (yazma_etkin && yo_yaz_hedef_g == coz_ky1_g) ? yo_yaz_veri_g : yazmac_q[coz_ky1_g];
    if (coz_ky2_g != '0)
      oku2_deger = (yazma_etkin && yo_yaz_hedef_g == coz_ky2_g) ? yo_yaz_veri_g : yazmac_q[coz_ky2_g];
  end

  // A write-back presented this cycle releases its register immediately, so it never counts as a hazard.
  assign raw1 = coz_ky1_oku_g && (coz_ky1_g != '0) && mesgul_q[coz_ky1_g] &&
                !(yazma_etkin && yo_yaz_hedef_g == coz_ky1_g);
  assign raw2 = coz_ky2_oku_g && (coz_ky2_g != '0) && mesgul_q[coz_ky2_g] &&
                !(yazma_etkin && yo_yaz_hedef_g == coz_ky2_g);
  assign waw  = coz_hy_yaz_g && (coz_hy_g != '0) && mesgul_q[coz_hy_g] &&
                !(yazma_etkin && yo_yaz_hedef_g == coz_hy_g);
  assign tehlike = raw1 || raw2 || waw;

  assign coz_hazir_c = !rst_g ||
                       (!tehlike && (!gecerli_q || yurut_hazir_g) && !boru_bosalt_g);
  assign aktarim     = coz_gecerli_g && coz_hazir_c && rst_g;

  always_comb begin
    yazmac_d = yazmac_q;
    mesgul_d = mesgul_q;
    gecerli_d = gecerli_q;
    deger1_d = deger1_q;
    deger2_d = deger2_q;
    if (yazma_etkin) begin
      yazmac_d[yo_yaz_hedef_g] = yo_yaz_veri_g;
      mesgul_d[yo_yaz_hedef_g] = 1'b0;
    end
    // The issue set is applied after the write-back clear so a same-index collision ends busy.
    if (boru_bosalt_g) begin
      mesgul_d  = '0;
      gecerli_d = 1'b0;
    end else if (aktarim) begin
      gecerli_d = 1'b1;
      deger1_d  = oku1_deger;
      deger2_d  = oku2_deger;
      if (coz_hy_yaz_g && coz_hy_g != '0)
        mesgul_d[coz_hy_g] = 1'b1;
    end else if (yurut_hazir_g) begin
      gecerli_d = 1'b0;
    end
  end

  always_ff @(posedge clk_g or negedge rst_g) begin
    if (!rst_g) begin
      yazmac_q  <= '{default: '0};
      mesgul_q  <= '0;
      gecerli_q <= 1'b0;
      deger1_q  <= '0;
      deger2_q  <= '0;
    end else begin
      yazmac_q  <= yazmac_d;
      mesgul_q  <= mesgul_d;
      gecerli_q <= gecerli_d;
      deger1_q  <= deger1_d;
      deger2_q  <= deger2_d;
    end
  end

  assign yurut_gecerli_c = gecerli_q;
  assign yurut_deger1_c  = deger1_q;
  assign yurut_deger2_c  = deger2_q;

endmodule

// File: tb/tb_yazmac_obegi.sv
// Self-checking bench for yazmac_obegi: directed scenarios plus randomized traffic
// checked against an array-based model of the register file and scoreboard.
module tb_yazmac_obegi;

  logic        clk_g = 1'b0;
  logic        rst_g;
  logic        yo_yaz_g;
  logic [4:0]  yo_yaz_hedef_g;
  logic [31:0] yo_yaz_veri_g;
  logic        coz_gecerli_g;
  logic        coz_hazir_c;
  logic [4:0]  coz_ky1_g, coz_ky2_g;
  logic        coz_ky1_oku_g, coz_ky2_oku_g;
  logic [4:0]  coz_hy_g;
  logic        coz_hy_yaz_g;
  logic        yurut_gecerli_c;
  logic [31:0] yurut_deger1_c, yurut_deger2_c;
  logic        yurut_hazir_g;
  logic        boru_bosalt_g;

  int nChecks = 0;
  int nPass   = 0;

  logic [31:0] mReg [32];
  bit          mBusy [32];
  bit          mValid;
  logic [31:0] mD1, mD2;

  yazmac_obegi #(.VERI_BIT(32), .ADRES_BIT(5)) dut (
    .clk_g(clk_g), .rst_g(rst_g),
    .yo_yaz_g(yo_yaz_g), .yo_yaz_hedef_g(yo_yaz_hedef_g), .yo_yaz_veri_g(yo_yaz_veri_g),
    .coz_gecerli_g(coz_gecerli_g), .coz_hazir_c(coz_hazir_c),
    .coz_ky1_g(coz_ky1_g), .coz_ky2_g(coz_ky2_g),
    .coz_ky1_oku_g(coz_ky1_oku_g), .coz_ky2_oku_g(coz_ky2_oku_g),
    .coz_hy_g(coz_hy_g), .coz_hy_yaz_g(coz_hy_yaz_g),
    .yurut_gecerli_c(yurut_gecerli_c), .yurut_deger1_c(yurut_deger1_c),
    .yurut_deger2_c(yurut_deger2_c), .yurut_hazir_g(yurut_hazir_g),
    .boru_bosalt_g(boru_bosalt_g)
  );

  always #5 clk_g = ~clk_g;

  // Model: reset clears everything.
  task automatic modelReset();
    for (int i = 0; i < 32; i++) begin
      mReg[i]  = '0;
      mBusy[i] = 1'b0;
    end
    mValid = 1'b0;
    mD1 = '0;
    mD2 = '0;
  endtask

  function automatic logic [31:0] modelRead(input logic [4:0] idx);
    if (idx == 0) return 32'h0;
    if (yo_yaz_g && yo_yaz_hedef_g == idx) return yo_yaz_veri_g;
    return mReg[idx];
  endfunction

  function automatic bit modelBlocked(input logic [4:0] idx);
    return idx != 0 && mBusy[idx] && !(yo_yaz_g && yo_yaz_hedef_g == idx);
  endfunction

  function automatic bit modelHazir();
    if (!rst_g) return 1'b1;
    if (boru_bosalt_g) return 1'b0;
    if (mValid && !yurut_hazir_g) return 1'b0;
    if (coz_ky1_oku_g && modelBlocked(coz_ky1_g)) return 1'b0;
    if (coz_ky2_oku_g && modelBlocked(coz_ky2_g)) return 1'b0;
    if (coz_hy_yaz_g && modelBlocked(coz_hy_g)) return 1'b0;
    return 1'b1;
  endfunction

  task automatic setIdle();
    yo_yaz_g = 0; yo_yaz_hedef_g = 0; yo_yaz_veri_g = 0;
    coz_gecerli_g = 0; coz_ky1_g = 0; coz_ky2_g = 0;
    coz_ky1_oku_g = 0; coz_ky2_oku_g = 0; coz_hy_g = 0; coz_hy_yaz_g = 0;
    yurut_hazir_g = 1; boru_bosalt_g = 0;
  endtask

  task automatic request(input logic [4:0] k1, input bit o1, input logic [4:0] k2, input bit o2,
                         input logic [4:0] hy, input bit hyYaz);
    coz_gecerli_g = 1; coz_ky1_g = k1; coz_ky1_oku_g = o1; coz_ky2_g = k2; coz_ky2_oku_g = o2;
    coz_hy_g = hy; coz_hy_yaz_g = hyYaz;
  endtask

  task automatic writeBack(input logic [4:0] idx, input logic [31:0] v);
    yo_yaz_g = 1; yo_yaz_hedef_g = idx; yo_yaz_veri_g = v;
  endtask

  // Advances one clock edge and the model alongside it; inputs stay stable across the edge.
  task automatic tick();
    bit hz, xfer;
    logic [31:0] r1, r2;
    hz = modelHazir();
    r1 = modelRead(coz_ky1_g);
    r2 = modelRead(coz_ky2_g);
    xfer = coz_gecerli_g && hz;
    @(posedge clk_g);
    if (yo_yaz_g && yo_yaz_hedef_g != 0) begin
      mReg[yo_yaz_hedef_g]  = yo_yaz_veri_g;
      mBusy[yo_yaz_hedef_g] = 1'b0;
    end
    if (boru_bosalt_g) begin
      for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
      mValid = 1'b0;
    end else if (xfer) begin
      mValid = 1'b1;
      mD1 = r1;
      mD2 = r2;
      if (coz_hy_yaz_g && coz_hy_g != 0) mBusy[coz_hy_g] = 1'b1;
    end else if (yurut_hazir_g) begin
      mValid = 1'b0;
    end
    #1;
  endtask

  task automatic test_reset();
    setIdle();
    rst_g = 0;
    boru_bosalt_g = 1;
    modelReset();
    #12;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL reset_hazir: got %b expected 1", coz_hazir_c); else nPass++;
    nChecks++; if (yurut_gecerli_c !== 1'b0) $display("[TB] FAIL reset_valid: got %b expected 0", yurut_gecerli_c); else nPass++;
    nChecks++; if (yurut_deger1_c !== 32'h0 || yurut_deger2_c !== 32'h0)
      $display("[TB] FAIL reset_data: got %h/%h expected 0/0", yurut_deger1_c, yurut_deger2_c); else nPass++;
    boru_bosalt_g = 0;
    rst_g = 1;
    @(posedge clk_g); #1;
  endtask

  task automatic test_x0_read();
    setIdle();
    request(5'd0, 1, 5'd5, 1, 5'd0, 0);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL x0_hazir: got %b expected 1", coz_hazir_c); else nPass++;
    tick();
    nChecks++; if (yurut_gecerli_c !== 1'b1) $display("[TB] FAIL x0_valid: got %b expected 1", yurut_gecerli_c); else nPass++;
    nChecks++; if (yurut_deger1_c !== 32'h0 || yurut_deger2_c !== 32'h0)
      $display("[TB] FAIL x0_data: got %h/%h expected 0/0", yurut_deger1_c, yurut_deger2_c); else nPass++;
  endtask

  task automatic test_bypass();
    setIdle();
    writeBack(5'd5, 32'hDEADBEEF);
    request(5'd5, 1, 5'd0, 0, 5'd0, 0);
    tick();
    nChecks++; if (yurut_deger1_c !== 32'hDEADBEEF) $display("[TB] FAIL bypass: got %h expected deadbeef", yurut_deger1_c); else nPass++;
    setIdle();
    writeBack(5'd0, 32'h1234);
    tick();
    setIdle();
    request(5'd0, 1, 5'd5, 1, 5'd0, 0);
    tick();
    nChecks++; if (yurut_deger1_c !== 32'h0) $display("[TB] FAIL x0_write_ignored: got %h expected 0", yurut_deger1_c); else nPass++;
    nChecks++; if (yurut_deger2_c !== 32'hDEADBEEF) $display("[TB] FAIL storage_read: got %h expected deadbeef", yurut_deger2_c); else nPass++;
  endtask

  task automatic test_raw_stall();
    setIdle();
    request(5'd0, 0, 5'd0, 0, 5'd7, 1);
    tick();
    setIdle();
    request(5'd1, 0, 5'd7, 1, 5'd0, 0);
    for (int c = 0; c < 3; c++) begin
      #1;
      nChecks++; if (coz_hazir_c !== 1'b0) $display("[TB] FAIL raw_stall_%0d: got %b expected 0", c, coz_hazir_c); else nPass++;
      tick();
    end
    writeBack(5'd7, 32'h55);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL raw_release: got %b expected 1", coz_hazir_c); else nPass++;
    tick();
    nChecks++; if (yurut_gecerli_c !== 1'b1 || yurut_deger2_c !== 32'h55)
      $display("[TB] FAIL raw_data: got %b/%h expected 1/00000055", yurut_gecerli_c, yurut_deger2_c); else nPass++;
    setIdle();
    request(5'd7, 1, 5'd0, 0, 5'd0, 0);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL x7_not_busy: got %b expected 1", coz_hazir_c); else nPass++;
    tick();
  endtask

  task automatic test_output_stall();
    setIdle();
    yurut_hazir_g = 0;
    request(5'd5, 1, 5'd0, 0, 5'd0, 0);
    for (int c = 0; c < 2; c++) begin
      #1;
      nChecks++; if (coz_hazir_c !== 1'b0) $display("[TB] FAIL stall_hazir_%0d: got %b expected 0", c, coz_hazir_c); else nPass++;
      tick();
      nChecks++; if (yurut_gecerli_c !== 1'b1 || yurut_deger1_c !== 32'h55)
        $display("[TB] FAIL stall_frozen_%0d: got %b/%h expected 1/00000055", c, yurut_gecerli_c, yurut_deger1_c); else nPass++;
    end
    yurut_hazir_g = 1;
    #1;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL stall_release: got %b expected 1", coz_hazir_c); else nPass++;
    tick();
    nChecks++; if (yurut_deger1_c !== 32'hDEADBEEF) $display("[TB] FAIL stall_new_data: got %h expected deadbeef", yurut_deger1_c); else nPass++;
  endtask

  task automatic test_back_to_back();
    setIdle();
    for (int i = 0; i < 4; i++) begin
      writeBack(5'(11 + i), 32'hA000_0000 + 32'(i));
      tick();
    end
    setIdle();
    for (int i = 0; i < 4; i++) begin
      request(5'(11 + i), 1, 5'd0, 0, 5'(20 + i), 1);
      #1;
      nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL b2b_hazir_%0d: got %b expected 1", i, coz_hazir_c); else nPass++;
      tick();
      nChecks++; if (yurut_deger1_c !== 32'hA000_0000 + 32'(i))
        $display("[TB] FAIL b2b_data_%0d: got %h expected %h", i, yurut_deger1_c, 32'hA000_0000 + 32'(i)); else nPass++;
    end
    setIdle();
    for (int i = 0; i < 4; i++) begin
      writeBack(5'(20 + i), 32'h0);
      tick();
    end
  endtask

  task automatic test_set_wins();
    setIdle();
    request(5'd0, 0, 5'd0, 0, 5'd3, 1);
    tick();
    writeBack(5'd3, 32'h33);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL setwins_accept: got %b expected 1", coz_hazir_c); else nPass++;
    tick();
    setIdle();
    request(5'd3, 1, 5'd0, 0, 5'd0, 0);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b0) $display("[TB] FAIL setwins_busy: got %b expected 0", coz_hazir_c); else nPass++;
    tick();
    writeBack(5'd3, 32'h77);
    tick();
    nChecks++; if (yurut_deger1_c !== 32'h77) $display("[TB] FAIL setwins_data: got %h expected 00000077", yurut_deger1_c); else nPass++;
  endtask

  task automatic test_flush();
    setIdle();
    request(5'd0, 0, 5'd0, 0, 5'd9, 1);
    tick();
    setIdle();
    yurut_hazir_g = 0;
    boru_bosalt_g = 1;
    writeBack(5'd10, 32'hA5A5);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b0) $display("[TB] FAIL flush_hazir: got %b expected 0", coz_hazir_c); else nPass++;
    tick();
    nChecks++; if (yurut_gecerli_c !== 1'b0) $display("[TB] FAIL flush_valid: got %b expected 0", yurut_gecerli_c); else nPass++;
    setIdle();
    request(5'd9, 1, 5'd10, 1, 5'd0, 0);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL flush_x9_free: got %b expected 1", coz_hazir_c); else nPass++;
    tick();
    nChecks++; if (yurut_deger2_c !== 32'hA5A5) $display("[TB] FAIL flush_write: got %h expected 0000a5a5", yurut_deger2_c); else nPass++;
  endtask

  task automatic test_random();
    int stuck;
    logic [4:0] busyList [$];
    stuck = 0;
    for (int c = 0; c < 400; c++) begin
      setIdle();
      busyList.delete();
      for (int i = 1; i < 32; i++) if (mBusy[i]) busyList.push_back(5'(i));
      if ($urandom_range(0, 1) == 1) begin
        if (busyList.size() > 0 && $urandom_range(0, 3) != 0)
          writeBack(busyList[$urandom_range(0, busyList.size() - 1)], $urandom);
        else
          writeBack(5'($urandom_range(0, 7)), $urandom);
      end
      if ($urandom_range(0, 9) < 7)
        request(5'($urandom_range(0, 7)), 1'($urandom), 5'($urandom_range(0, 7)), 1'($urandom),
                5'($urandom_range(0, 7)), 1'($urandom));
      yurut_hazir_g = ($urandom_range(0, 3) != 0);
      boru_bosalt_g = ($urandom_range(0, 24) == 0);
      #1;
      nChecks++; if (coz_hazir_c !== modelHazir())
        $display("[TB] FAIL rnd_hazir_%0d: got %b expected %b", c, coz_hazir_c, modelHazir()); else nPass++;
      tick();
      nChecks++; if (yurut_gecerli_c !== mValid || yurut_deger1_c !== mD1 || yurut_deger2_c !== mD2)
        $display("[TB] FAIL rnd_out_%0d: got %b/%h/%h expected %b/%h/%h", c, yurut_gecerli_c,
                 yurut_deger1_c, yurut_deger2_c, mValid, mD1, mD2); else nPass++;
    end
    setIdle();
    boru_bosalt_g = 1;
    tick();
  endtask

  task automatic test_reset_midstall();
    setIdle();
    request(5'd0, 0, 5'd0, 0, 5'd4, 1);
    tick();
    setIdle();
    request(5'd4, 1, 5'd0, 0, 5'd0, 0);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b0) $display("[TB] FAIL midstall_stalled: got %b expected 0", coz_hazir_c); else nPass++;
    rst_g = 0;
    modelReset();
    #1;
    nChecks++; if (yurut_gecerli_c !== 1'b0 || yurut_deger1_c !== 32'h0 || yurut_deger2_c !== 32'h0)
      $display("[TB] FAIL midstall_reset_out: got %b/%h/%h expected 0/0/0", yurut_gecerli_c, yurut_deger1_c, yurut_deger2_c); else nPass++;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL midstall_reset_hazir: got %b expected 1", coz_hazir_c); else nPass++;
    #1;
    rst_g = 1;
    setIdle();
    @(posedge clk_g); #1;
    request(5'd5, 1, 5'd4, 1, 5'd0, 0);
    #1;
    nChecks++; if (coz_hazir_c !== 1'b1) $display("[TB] FAIL postreset_hazir: got %b expected 1", coz_hazir_c); else nPass++;
    tick();
    nChecks++; if (yurut_gecerli_c !== 1'b1 || yurut_deger1_c !== 32'h0)
      $display("[TB] FAIL postreset_cleared: got %b/%h expected 1/0", yurut_gecerli_c, yurut_deger1_c); else nPass++;
  endtask

  initial begin
    test_reset();
    test_x0_read();
    test_bypass();
    test_raw_stall();
    test_output_stall();
    test_back_to_back();
    test_set_wins();
    test_flush();
    test_random();
    test_reset_midstall();
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
